hack_alu_pipe: RTL and testbench

HACK_ALU_PIPE -- requirements
Module: hack_alu_pipe

---
 rtl/hack_pkg.sv | 16 +
 rtl/hack_alu_preset.sv | 23 ++
 rtl/hack_alu_pipe.sv | 133 +++++++++++++
 tb/tb_hack_alu_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared constants for the Hack ALU pipeline
// Purpose: default datapath width and the bit positions of the six Hack
// control flags inside the 6-bit ctrl word {zx,nx,zy,ny,f,no}.
// Ports: none (package).
package hack_pkg;

  localparam int HACK_N = 16;

  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

endpackage

// File: rtl/hack_alu_preset.sv
// rtl/hack_alu_preset.sv - Hack operand preset (zero then negate)
// Purpose: combinational operand conditioning applied to each ALU input.
// Ports:
//   in  [N-1:0]  raw operand
//   z            force operand to zero
//   n            bitwise-invert the (possibly zeroed) operand
//   out [N-1:0]  conditioned operand
module hack_alu_preset #(
  parameter int N = 16
) (
  input  logic [N-1:0] in,
  input  logic         z,
  input  logic         n,
  output logic [N-1:0] out
);

  logic [N-1:0] zeroed;

  // Zeroing happens before inversion, so z=1,n=1 yields all ones.
  assign zeroed = z ? '0 : in;
  assign out    = n ? ~zeroed : zeroed;

endmodule

// File: rtl/hack_alu_pipe.sv
// rtl/hack_alu_pipe.sv - two-stage valid/ready pipelined Hack ALU
// Purpose: stage 1 registers preset operands plus f/no, stage 2 registers
// the result with its zr/ng flags; both stages stall under backpressure.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (x, y, ctrl)
//   x, y [N-1:0]          raw operands
//   ctrl [5:0]            {zx,nx,zy,ny,f,no}
//   out_valid / out_ready result handshake (out, zr, ng)
//   out [N-1:0]           ALU result; zr = (out==0), ng = out[N-1]
//   op_count [15:0]       wrapping count of delivered results
module hack_alu_pipe
  import hack_pkg::*;
#(
  parameter int N = HACK_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [5:0]   ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         zr,
  output logic         ng,
  output logic [15:0]  op_count
);

  logic [N-1:0] x_pre;
  logic [N-1:0] y_pre;

  hack_alu_preset #(.N(N)) u_preset_x (
    .in  (x),
    .z   (ctrl[ZX]),
    .n   (ctrl[NX]),
    .out (x_pre)
  );

  hack_alu_preset #(.N(N)) u_preset_y (
    .in  (y),
    .z   (ctrl[ZY]),
    .n   (ctrl[NY]),
    .out (y_pre)
  );

  // Stage 1 state
  logic         s1_valid;
  logic [N-1:0] s1_x;
  logic [N-1:0] s1_y;
  logic         s1_f;
  logic         s1_no;

  // Stage 2 state
  logic         s2_valid;
  logic [N-1:0] s2_out;
  logic         s2_zr;
  logic         s2_ng;

  logic [15:0]  cnt;

  logic         out_xfer;
  logic         s1_adv;
  logic         in_xfer;
  logic [N-1:0] alu_fn;
  logic [N-1:0] alu_res;

  // Ready chains backwards combinationally so a full pipe keeps
  // accepting one set per cycle while the consumer keeps taking results.
  assign out_xfer = s2_valid & out_ready;
  assign s1_adv   = ~s2_valid | out_xfer;
  assign in_ready = ~s1_valid | s1_adv;
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    alu_fn  = s1_f ? (s1_x + s1_y) : (s1_x & s1_y);
    alu_res = s1_no ? ~alu_fn : alu_fn;
  end

  // When stage 1 can move, an idle input cycle loads a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Operand payload needs no reset: it is only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_x  <= x_pre;
      s1_y  <= y_pre;
      s1_f  <= ctrl[F];
      s1_no <= ctrl[NO];
    end
  end

  // Result register only reloads on a real operand set, so out/zr/ng stay
  // frozen both under stall and while bubbles pass through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_zr    <= 1'b0;
      s2_ng    <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_out <= alu_res;
        s2_zr  <= (alu_res == '0);
        s2_ng  <= alu_res[N-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (out_xfer) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign out_valid = s2_valid;
  assign out       = s2_out;
  assign zr        = s2_zr;
  assign ng        = s2_ng;
  assign op_count  = cnt;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb/tb_hack_alu_pipe.sv - self-checking bench for hack_alu_pipe
module tb_hack_alu_pipe;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic [5:0]   ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         zr;
  logic         ng;
  logic [15:0]  op_count;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [15:0]  exp_cnt;
  logic [N-1:0] exp_q[$];

  hack_alu_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Hack ALU evaluated with integer arithmetic: NOT of an N-bit value v is
  // (2^N - 1) - v, addition is taken modulo 2^N.
  function automatic logic [N-1:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [5:0] c);
    longint unsigned m, xa, yb, r;
    m  = (64'd1 << N) - 64'd1;
    xa = c[5] ? 64'd0 : 64'(a);
    if (c[4]) xa = m - xa;
    yb = c[3] ? 64'd0 : 64'(b);
    if (c[2]) yb = m - yb;
    r  = c[1] ? (xa + yb) % (m + 64'd1) : (xa & yb);
    if (c[0]) r = m - r;
    return r[N-1:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; ctrl = '0; exp_cnt = 16'd0;
    #2;
    n_cmp++;
    if ({out_valid, in_ready, out, zr, ng, op_count} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_async got v=%b rdy=%b out=%h zr=%b ng=%b cnt=%h want v=0 rdy=1 out=0 zr=0 ng=0 cnt=0",
               out_valid, in_ready, out, zr, ng, op_count);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready, op_count} !== {1'b0, 1'b1, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_held got v=%b rdy=%b cnt=%h want 0 1 0000", out_valid, in_ready, op_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    in_valid = 1'b1; x = 16'd15; y = 16'd9; ctrl = 6'b000010; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL add_first_accept got in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL add_latency_early got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'd24, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL add_result got v=%b out=%0d zr=%b ng=%b want v=1 out=24 zr=0 ng=0", out_valid, out, zr, ng);
    end
    @(posedge clk); #1;
    exp_cnt++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; x = 16'd15; y = 16'd9; ctrl = 6'b000000; out_ready = 1'b1;
    @(posedge clk); #1;
    ctrl = 6'b000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'd9, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_and got v=%b out=%h zr=%b ng=%b want v=1 out=0009 zr=0 ng=0", out_valid, out, zr, ng);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'hFFF6, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_nand got v=%b out=%h zr=%b ng=%b want v=1 out=fff6 zr=0 ng=1", out_valid, out, zr, ng);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_bubble got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd2;
  endtask

  task automatic test_consts();
    in_valid = 1'b1; x = N'($urandom); y = N'($urandom); ctrl = 6'b111111; out_ready = 1'b1;
    @(posedge clk); #1;
    x = N'($urandom); y = N'($urandom); ctrl = 6'b101010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL const_one got v=%b out=%h zr=%b ng=%b want v=1 out=0001 zr=0 ng=0", out_valid, out, zr, ng);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out, zr, ng} !== {1'b1, 16'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL const_zero got v=%b out=%h zr=%b ng=%b want v=1 out=0000 zr=1 ng=0", out_valid, out, zr, ng);
    end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd2;
    @(negedge clk);
    n_cmp++;
    if (op_count !== exp_cnt) begin
      n_bad++; $display("FAIL const_op_count got %0d want %0d", op_count, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [N-1:0] sx[4];
    logic [N-1:0] sy[4];
    logic [5:0]   sc[4];
    logic [N-1:0] se[4];
    int idx;
    int got;
    logic ix;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sx[i] = N'($urandom); sy[i] = N'($urandom); sc[i] = 6'($urandom);
      se[i] = ref_alu(sx[i], sy[i], sc[i]);
    end
    idx = 0; got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; x = sx[idx]; y = sy[idx]; ctrl = sc[idx];
      @(negedge clk);
      if (c >= 2) begin
        n_cmp++;
        if ({in_ready, out_valid, out} !== {1'b0, 1'b1, se[0]}) begin
          n_bad++;
          $display("FAIL stall_hold c=%0d got rdy=%b v=%b out=%h want rdy=0 v=1 out=%h",
                   c, in_ready, out_valid, out, se[0]);
        end
      end
      ix = in_valid & in_ready;
      @(posedge clk); #1;
      if (ix) idx++;
    end
    n_cmp++;
    if (idx !== 2) begin
      n_bad++; $display("FAIL stall_accepts got %0d want 2", idx);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin x = sx[idx]; y = sy[idx]; ctrl = sc[idx]; end
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out !== se[got]) begin
          n_bad++; $display("FAIL stall_order item=%0d got %h want %h", got, out, se[got]);
        end
        got++;
      end
      ix = in_valid & in_ready;
      @(posedge clk); #1;
      if (ix) idx++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({got, op_count, out_valid} !== {32'd4, 16'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL stall_drain got results=%0d op_count=%0d v=%b want 4 4 0", got, op_count, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      x = N'($urandom); y = N'($urandom); ctrl = 6'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_bad++; $display("FAIL rstmid_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, op_count, in_ready, out} !== {1'b0, 16'h0, 1'b1, 16'h0}) begin
      n_bad++;
      $display("FAIL rstmid_immediate got v=%b cnt=%h rdy=%b out=%h want 0 0000 1 0000",
               out_valid, op_count, in_ready, out);
    end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    exp_q.delete(); exp_cnt = 16'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_stale c=%0d got out_valid=%b want 0", c, out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic         prev_stall;
    logic [N-1:0] prev_out;
    logic [N-1:0] e;
    logic         want_rdy;
    prev_stall = 1'b0; prev_out = '0;
    for (int c = 0; c < 620; c++) begin
      if (c < 600) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      x = N'($urandom); y = N'($urandom); ctrl = 6'($urandom);
      @(negedge clk);
      // At most two sets can be in flight; with two held, room appears
      // only if the consumer takes one this cycle.
      want_rdy = (exp_q.size() < 2) || out_ready;
      n_cmp++;
      if (in_ready !== want_rdy) begin
        n_bad++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, in_ready, want_rdy);
      end
      n_cmp++;
      if (out_valid === 1'b1 && exp_q.size() == 0) begin
        n_bad++; $display("FAIL rnd_phantom c=%0d got out_valid=1 want 0 (nothing in flight)", c);
      end
      if (prev_stall) begin
        n_cmp++;
        if ({out_valid, out} !== {1'b1, prev_out}) begin
          n_bad++; $display("FAIL rnd_hold c=%0d got v=%b out=%h want v=1 out=%h", c, out_valid, out, prev_out);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_cnt++;
        n_cmp++;
        if ({out, zr, ng} !== {e, (e == '0), e[N-1]}) begin
          n_bad++;
          $display("FAIL rnd_result c=%0d got out=%h zr=%b ng=%b want out=%h zr=%b ng=%b",
                   c, out, zr, ng, e, (e == '0), e[N-1]);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_alu(x, y, ctrl));
      prev_stall = out_valid & ~out_ready;
      prev_out   = out;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if ({exp_q.size(), op_count} !== {32'd0, exp_cnt}) begin
      n_bad++;
      $display("FAIL rnd_drain got left=%0d op_count=%0d want 0 %0d", exp_q.size(), op_count, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int stalls;
    do_reset();
    stalls = 0;
    x = 16'd1; y = 16'd2; ctrl = 6'b000010; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) stalls++;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({op_count, stalls} !== {16'hFFFF, 32'd0}) begin
      n_bad++; $display("FAIL wrap_full got op_count=%h stalls=%0d want ffff 0", op_count, stalls);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (op_count !== 16'h0000) begin
      n_bad++; $display("FAIL wrap_zero got op_count=%h want 0000", op_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_consts();
    test_stall();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
